// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce and one-entry key buffer (optional AUTO_REPEAT_EN auto-repeat)
module keypad_scan #(
  parameter int SCAN_DIV      = 1000,
  parameter int DB_FRAMES     = 4,
  parameter int REPEAT_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] col,
  input  logic       key_rd,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overflow
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DB_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t          state, state_n;
  logic [3:0]      s1, s2;
  logic [SW-1:0]   slot;
  logic [1:0]      ridx;
  logic [11:0]     keys;
  logic [15:0]     frame;
  logic            slot_end, frame_end;
  logic [4:0]      nk;
  logic [3:0]      kc;
  logic            none, single;
  logic [DW-1:0]   cnt, cnt_n, cnt_inc;
  logic [3:0]      cand, cand_n, push_code;
  logic            push, push_r, rep_push;
  assign slot_end  = slot == SW'(SCAN_DIV - 1);
  assign frame_end = slot_end && ridx == 2'd3;
  assign frame     = {~s2, keys};
  assign none      = nk == 5'd0;
  assign single    = nk == 5'd1;
  assign cnt_inc   = cnt + 1'b1;
`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep, rep_inc;
  assign rep_inc  = rep + 1'b1;
  assign rep_push = frame_end && state == PRESSED && rep_inc == RW'(REPEAT_FRAMES);
  // Frame counter while held; survives a release bounce, cleared once back in IDLE
  always_ff @(posedge clk) begin
    if (rstn || state_n == IDLE) rep <= '0;
    else if (frame_end && state == PRESSED) rep <= rep_push ? '0 : rep_inc;
  end
`else
  assign rep_push = 1'b0;
`endif
  // Column synchronizer, slot timer, row rotation and per-row column capture
  always_ff @(posedge clk) begin
    if (rstn) begin
      s1   <= 4'hF;
      s2   <= 4'hF;
      slot <= '0;
      ridx <= 2'd0;
      row  <= 4'b1110;
      keys <= '0;
    end else begin
      s1 <= col;
      s2 <= s1;
      if (slot_end) begin
        slot <= '0;
        ridx <= ridx + 2'd1;
        row  <= {row[2:0], row[3]};
        case (ridx)
          2'd0:    keys[3:0]  <= ~s2;
          2'd1:    keys[7:4]  <= ~s2;
          2'd2:    keys[11:8] <= ~s2;
          default: ;
        endcase
      end else begin
        slot <= slot + 1'b1;
      end
    end
  end
  // Count keys down in the frame; row 3 is taken live from the synchronizer
  always_comb begin
    nk = '0;
    kc = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        nk = nk + 1'b1;
        kc = 4'(i);
      end
    end
  end
  // Debounce FSM next state, evaluated only on frame end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    push    = rep_push;
    if (frame_end) begin
      case (state)
        IDLE: if (single) begin
          cand_n = kc;
          cnt_n  = DW'(1);
          if (DB_FRAMES == 1) begin
            push    = 1'b1;
            state_n = PRESSED;
          end else state_n = DEBOUNCE;
        end
        DEBOUNCE: if (single && kc == cand) begin
          cnt_n = cnt_inc;
          if (cnt_inc == DW'(DB_FRAMES)) begin
            push    = 1'b1;
            state_n = PRESSED;
          end
        end else state_n = IDLE;
        PRESSED: if (none) begin
          cnt_n   = DW'(1);
          state_n = (DB_FRAMES == 1) ? IDLE : RELEASE;
        end
        RELEASE: if (none) begin
          cnt_n = cnt_inc;
          if (cnt_inc == DW'(DB_FRAMES)) state_n = IDLE;
        end else state_n = PRESSED;
        default: state_n = IDLE;
      endcase
    end
  end
  // FSM state register and held-key indication
  always_ff @(posedge clk) begin
    if (rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      key_down <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cand     <= cand_n;
      key_down <= state == PRESSED || state == RELEASE;
    end
  end
  // Single-entry output buffer: a push beats a read, a push onto a full buffer is lost
  always_ff @(posedge clk) begin
    if (rstn) begin
      push_r    <= 1'b0;
      push_code <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      push_r    <= push;
      push_code <= cand_n;
      if (push_r) begin
        if (key_valid && !key_rd) overflow <= 1'b1;
        else begin
          key_valid <= 1'b1;
          key_code  <= push_code;
        end
      end else if (key_rd) key_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: table-driven check of keypad_scan with SCAN_DIV=4, DB_FRAMES=3
module tb_keypad_scan;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  col;
  logic        key_rd = 1'b0;
  logic [3:0]  row, key_code;
  logic        key_valid, key_down, overflow;
  logic [15:0] keys = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  typedef struct {
    logic [15:0] keys;
    int          frames;
    bit          rd;
    bit          v;
    logic [3:0]  c;
    bit          d;
    bit          o;
  } vec_t;
  vec_t tv [20];
  keypad_scan #(.SCAN_DIV(4), .DB_FRAMES(3), .REPEAT_FRAMES(16)) dut (
    .clk(clk), .rstn(rstn), .col(col), .key_rd(key_rd), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col[c] = 1'b0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
  endtask
  task automatic step(input vec_t t);
    keys   = t.keys;
    key_rd = t.rd;
    @(negedge clk);
    key_rd = 1'b0;
    repeat (t.frames * 16 - 1) @(negedge clk);
  endtask
  initial begin
    logic [3:0] rexp [4];
    rexp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tv[0]  = '{16'h0200, 2, 0, 0, 4'd0, 0, 0};
    tv[1]  = '{16'h0200, 1, 0, 1, 4'd9, 1, 0};
    tv[2]  = '{16'h0200, 1, 1, 0, 4'd9, 1, 0};
    tv[3]  = '{16'h0200, 2, 0, 0, 4'd9, 1, 0};
    tv[4]  = '{16'h0000, 2, 0, 0, 4'd9, 1, 0};
    tv[5]  = '{16'h0000, 1, 0, 0, 4'd9, 0, 0};
    tv[6]  = '{16'h0080, 2, 0, 0, 4'd9, 0, 0};
    tv[7]  = '{16'h0000, 1, 0, 0, 4'd9, 0, 0};
    tv[8]  = '{16'h0080, 2, 0, 0, 4'd9, 0, 0};
    tv[9]  = '{16'h0000, 2, 0, 0, 4'd9, 0, 0};
    tv[10] = '{16'h8001, 5, 0, 0, 4'd9, 0, 0};
    tv[11] = '{16'h0001, 2, 0, 0, 4'd9, 0, 0};
    tv[12] = '{16'h0001, 1, 0, 1, 4'd0, 1, 0};
    tv[13] = '{16'h0001, 1, 1, 0, 4'd0, 1, 0};
    tv[14] = '{16'h0000, 3, 0, 0, 4'd0, 0, 0};
    tv[15] = '{16'h0004, 3, 0, 1, 4'd2, 1, 0};
    tv[16] = '{16'h0000, 3, 0, 1, 4'd2, 0, 0};
    tv[17] = '{16'h0010, 3, 0, 1, 4'd2, 1, 1};
    tv[18] = '{16'h0000, 3, 0, 1, 4'd2, 0, 1};
    tv[19] = '{16'h0000, 1, 1, 0, 4'd2, 0, 1};
    do_reset();
    chk("reset valid", key_valid, 0);
    chk("reset code", key_code, 0);
    chk("reset down", key_down, 0);
    chk("reset overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("row slot %0d", i), row, rexp[i]);
      repeat (4) @(negedge clk);
    end
    chk("row wrap", row, 4'b1110);
    for (int i = 0; i < 20; i++) begin
      step(tv[i]);
      chk($sformatf("v%0d valid", i), key_valid, tv[i].v);
      chk($sformatf("v%0d code", i), key_code, tv[i].c);
      chk($sformatf("v%0d down", i), key_down, tv[i].d);
      chk($sformatf("v%0d overflow", i), overflow, tv[i].o);
    end
    keys = 16'h4000;
    repeat (32) @(negedge clk);
    do_reset();
    chk("rst mid valid", key_valid, 0);
    chk("rst mid down", key_down, 0);
    chk("rst mid overflow", overflow, 0);
    repeat (47) @(negedge clk);
    chk("rst early valid", key_valid, 0);
    @(negedge clk);
    chk("rst push valid", key_valid, 1);
    chk("rst push code", key_code, 4'd14);
    chk("rst push down", key_down, 1);
    keys = '0;
    do_reset();
    keys = 16'h0004;
    repeat (48) @(negedge clk);
    chk("ovr first valid", key_valid, 1);
    chk("ovr first code", key_code, 4'd2);
    keys = '0;
    repeat (48) @(negedge clk);
    keys = 16'h0010;
    repeat (47) @(negedge clk);
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
    chk("push+rd valid", key_valid, 1);
    chk("push+rd code", key_code, 4'd4);
    chk("push+rd overflow", overflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
